// File: rtl/sample_fetch_if.sv
// ============================================================================
// Module      : sample_fetch_if
// Description : Sample-memory read bus plus serializer request/delivery bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sample_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  sample_req;
    logic [DATA_WIDTH-1:0] sample_out;
    logic                  sample_valid;
    logic                  underrun;

    // Fetch engine side
    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        input  sample_req,
        output sample_out,
        output sample_valid,
        output underrun
    );

    // Memory / serializer side
    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        output sample_req,
        input  sample_out,
        input  sample_valid,
        input  underrun
    );
endinterface

`default_nettype wire

// File: rtl/sample_fetch.sv
// ============================================================================
// Module      : sample_fetch
// Description : Looping sample-memory walker with one-sample prefetch,
//               attenuation on delivery and saturating underrun counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  enable,
    input  wire logic [ADDR_WIDTH-1:0] start_addr,
    input  wire logic [ADDR_WIDTH-1:0] end_addr,
    input  wire logic [3:0]            atten,
    sample_fetch_if.master             bus,
    output logic      [15:0]           underrun_count,
    output logic                       playing
);

    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_s;
    logic [ADDR_WIDTH-1:0] r_e;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [DATA_WIDTH-1:0] r_sample_out;
    logic                  r_sample_valid;
    logic                  r_underrun;
    logic [15:0]           r_count;

    logic                  w_latch;
    logic                  w_advance;
    logic                  w_buf_load;
    logic                  w_deliver;
    logic                  w_zero;
    logic                  w_underrun;
    logic [DATA_WIDTH-1:0] w_src;
    logic [DATA_WIDTH-1:0] w_shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A request is honoured under the current state's rules even when
    // enable falls in the same cycle; only the next state is forced to IDLE.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_advance    = 1'b0;
        w_buf_load   = 1'b0;
        w_deliver    = 1'b0;
        w_zero       = 1'b0;
        w_underrun   = 1'b0;
        w_src        = r_buf;
        case (r_state)
            S_IDLE: begin
                if (bus.sample_req) begin
                    w_zero     = 1'b1;
                    w_underrun = enable;
                end
                if (enable) begin
                    w_latch      = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.sample_req) begin
                    w_zero     = 1'b1;
                    w_underrun = 1'b1;
                end
                w_next_state = enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                w_advance = 1'b1;
                w_src     = bus.mem_rdata;
                if (bus.sample_req) begin
                    w_deliver    = 1'b1;
                    w_next_state = enable ? S_FETCH : S_IDLE;
                end else begin
                    w_buf_load   = enable;
                    w_next_state = enable ? S_FULL : S_IDLE;
                end
            end
            S_FULL: begin
                if (bus.sample_req) begin
                    w_deliver    = 1'b1;
                    w_next_state = enable ? S_FETCH : S_IDLE;
                end else if (!enable) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_shifted = $signed(w_src) >>> atten;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= '0;
            r_s            <= '0;
            r_e            <= '0;
            r_buf          <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_underrun     <= 1'b0;
            r_count        <= '0;
        end else begin
            r_sample_valid <= w_deliver;
            r_underrun     <= w_underrun;
            if (w_deliver) begin
                r_sample_out <= w_shifted;
            end else if (w_zero) begin
                r_sample_out <= '0;
            end
            if (w_underrun && (r_count != c_COUNT_MAX)) begin
                r_count <= r_count + 16'd1;
            end
            if (w_latch) begin
                r_s    <= start_addr;
                r_e    <= end_addr;
                r_addr <= start_addr;
            end else if (w_advance) begin
                r_addr <= (r_addr == r_e) ? r_s : r_addr + ADDR_WIDTH'(1);
            end
            if (w_buf_load) begin
                r_buf <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr     = r_addr;
    assign bus.mem_rd_en    = (r_state == S_FETCH);
    assign bus.sample_out   = r_sample_out;
    assign bus.sample_valid = r_sample_valid;
    assign bus.underrun     = r_underrun;
    assign underrun_count   = r_count;
    assign playing          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sample_fetch.sv
// ============================================================================
// Module      : tb_sample_fetch
// Description : Self-checking bench for sample_fetch against a readiness-timer
//               reference model of the sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_fetch;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [3:0]    atten;
    logic [15:0]   underrun_count;
    logic          playing;

    always #5 clk = ~clk;

    sample_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sample_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .start_addr     (start_addr),
        .end_addr       (end_addr),
        .atten          (atten),
        .bus            (bus),
        .underrun_count (underrun_count),
        .playing        (playing)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_log [$];
    logic [DW-1:0] got [$];

    // Sample memory: one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_log.push_back(bus.mem_addr);
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: a sample becomes ready m_wait cycles after it is requested
    bit            m_play;
    int            m_wait;
    logic [AW-1:0] m_ptr, m_s, m_e;
    logic [DW-1:0] m_out;
    int            m_cnt;

    function automatic logic [DW-1:0] shaped(input logic [DW-1:0] v, input logic [3:0] a);
        logic signed [DW-1:0] t;
        t = v;
        return t >>> a;
    endfunction

    task automatic model_clear();
        m_play = 0; m_wait = 0; m_ptr = '0; m_s = '0; m_e = '0; m_out = '0; m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; bus.sample_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic cycle(input logic en, input logic req);
        bit exp_valid, exp_under, exp_rd;
        @(negedge clk);
        enable = en;
        bus.sample_req = req;
        exp_valid = 0;
        exp_under = 0;
        if (!m_play) begin
            if (req) begin
                m_out = '0;
                if (en) exp_under = 1;
            end
            if (en) begin
                m_play = 1; m_s = start_addr; m_e = end_addr; m_ptr = start_addr; m_wait = 2;
            end
        end else begin
            if (m_wait > 0) m_wait--;
            if (req) begin
                if (m_wait == 0) begin
                    m_out = shaped(mem[m_ptr], atten);
                    exp_valid = 1;
                    m_ptr = (m_ptr == m_e) ? m_s : m_ptr + AW'(1);
                    m_wait = 2;
                end else begin
                    exp_under = 1;
                    m_out = '0;
                end
            end
            if (!en) m_play = 0;
        end
        if (exp_under && m_cnt < 65535) m_cnt++;
        exp_rd = m_play && (m_wait == 2);
        @(posedge clk);
        #1;
        checks++;
        if (playing !== m_play) begin
            errors++; $display("FAIL playing: got %0b want %0b @%0t", playing, m_play, $time);
        end
        checks++;
        if (bus.mem_rd_en !== exp_rd) begin
            errors++; $display("FAIL mem_rd_en: got %0b want %0b @%0t", bus.mem_rd_en, exp_rd, $time);
        end
        if (exp_rd) begin
            checks++;
            if (bus.mem_addr !== m_ptr) begin
                errors++; $display("FAIL mem_addr: got %0d want %0d @%0t", bus.mem_addr, m_ptr, $time);
            end
        end
        checks++;
        if (bus.sample_valid !== exp_valid) begin
            errors++; $display("FAIL sample_valid: got %0b want %0b @%0t", bus.sample_valid, exp_valid, $time);
        end
        checks++;
        if (bus.underrun !== exp_under) begin
            errors++; $display("FAIL underrun: got %0b want %0b @%0t", bus.underrun, exp_under, $time);
        end
        checks++;
        if (bus.sample_out !== m_out) begin
            errors++; $display("FAIL sample_out: got %h want %h @%0t", bus.sample_out, m_out, $time);
        end
        checks++;
        if (underrun_count !== 16'(m_cnt)) begin
            errors++; $display("FAIL underrun_count: got %0d want %0d @%0t", underrun_count, m_cnt, $time);
        end
        if (bus.sample_valid) got.push_back(bus.sample_out);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.mem_addr, bus.mem_rd_en, bus.sample_out, bus.sample_valid, bus.underrun,
             underrun_count, playing} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%0d rd=%0b out=%h v=%0b u=%0b cnt=%0d play=%0b want all 0",
                     bus.mem_addr, bus.mem_rd_en, bus.sample_out, bus.sample_valid, bus.underrun,
                     underrun_count, playing);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = DW'(i + 1);
        start_addr = 0; end_addr = 3; atten = 0;
        got.delete(); rd_log.delete();
        cycle(1, 0);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 9; j++) cycle(1, 0);
            cycle(1, 1);
        end
        cycle(0, 0); cycle(0, 0);
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL seq_count: got %0d samples want 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (got[k] !== DW'(k % 4 + 1)) begin
                    errors++; $display("FAIL seq_sample[%0d]: got %h want %h", k, got[k], k % 4 + 1);
                end
            end
        end
        checks++;
        if (rd_log.size() < 6) begin
            errors++; $display("FAIL seq_reads: got %0d reads want >=6", rd_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (rd_log[k] !== AW'(k % 4)) begin
                    errors++; $display("FAIL seq_addr[%0d]: got %0d want %0d", k, rd_log[k], k % 4);
                end
            end
        end
        checks++;
        if (underrun_count !== 16'd0) begin
            errors++; $display("FAIL seq_underruns: got %0d want 0", underrun_count);
        end
    endtask

    task automatic test_atten();
        mem[5] = 16'h8000;
        atten = 4; start_addr = 5; end_addr = 5;
        got.delete(); rd_log.delete();
        cycle(1, 0);
        for (int j = 0; j < 4; j++) cycle(1, 0);
        cycle(1, 1);
        for (int j = 0; j < 3; j++) cycle(1, 0);
        cycle(0, 0); cycle(0, 0);
        checks++;
        if (got.size() != 1 || got[0] !== 16'hF800) begin
            errors++; $display("FAIL atten_sample: got %0d samples first %h want 1 of f800",
                               got.size(), (got.size() > 0) ? got[0] : 16'h0);
        end
        checks++;
        if (rd_log.size() < 2 || rd_log[1] !== AW'(5)) begin
            errors++; $display("FAIL atten_refetch: got %0d reads want second read at 5", rd_log.size());
        end
    endtask

    task automatic test_back_to_back();
        int cnt0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        start_addr = 10; end_addr = 20;
        got.delete();
        cnt0 = int'(underrun_count);
        for (int j = 0; j < 40; j++) begin
            atten = 4'($urandom_range(0, 15));
            cycle(1, 1);
        end
        cycle(0, 0); cycle(0, 0);
        checks++;
        if (got.size() != 19) begin
            errors++; $display("FAIL b2b_deliveries: got %0d want 19", got.size());
        end
        checks++;
        if (int'(underrun_count) - cnt0 != 21) begin
            errors++; $display("FAIL b2b_underruns: got %0d want 21", int'(underrun_count) - cnt0);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [6];
        exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd1022, 10'd1023};
        start_addr = 1022; end_addr = 1; atten = 0;
        rd_log.delete();
        cycle(1, 0);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 7; j++) cycle(1, 0);
            cycle(1, 1);
        end
        cycle(0, 0); cycle(0, 0);
        checks++;
        if (rd_log.size() < 6) begin
            errors++; $display("FAIL wrap_reads: got %0d reads want >=6", rd_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (rd_log[k] !== exp_a[k]) begin
                    errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, rd_log[k], exp_a[k]);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [DW-1:0] held;
        start_addr = 3; end_addr = 9; atten = 1;
        held = bus.sample_out;
        got.delete();
        cycle(1, 0);
        cycle(1, 0);
        cycle(0, 0);
        start_addr = 7;
        for (int j = 0; j < 5; j++) cycle(0, 0);
        rd_log.delete();
        cycle(1, 0);
        cycle(1, 0);
        checks++;
        if (got.size() != 0) begin
            errors++; $display("FAIL drop_valid: got %0d pulses want 0", got.size());
        end
        checks++;
        if (rd_log.size() < 1 || rd_log[0] !== AW'(7)) begin
            errors++; $display("FAIL drop_restart_addr: got %0d reads first %0d want 7",
                               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : AW'(0));
        end
        checks++;
        if (bus.sample_out !== held) begin
            errors++; $display("FAIL drop_hold: got %h want %h", bus.sample_out, held);
        end
        cycle(1, 1);
        cycle(0, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            atten = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                start_addr = AW'($urandom);
                end_addr   = AW'($urandom);
            end
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0);
        end
        cycle(0, 0);
    endtask

    task automatic test_saturate();
        do_reset();
        start_addr = 0; end_addr = 3;
        for (int j = 0; j < 32768; j++) begin
            cycle(1, 1);
            cycle(0, 1);
        end
        cycle(1, 1);
        cycle(0, 1);
        checks++;
        if (underrun_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_count: got %h want ffff", underrun_count);
        end
        do_reset();
        checks++;
        if (underrun_count !== 16'h0) begin
            errors++; $display("FAIL sat_reset: got %h want 0", underrun_count);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; start_addr = '0; end_addr = '0; atten = '0;
        bus.sample_req = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        model_clear();
        test_reset();
        test_sequence();
        test_atten();
        test_back_to_back();
        test_wrap();
        test_enable_drop();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
